// File: rtl/rvvi_tx_scheduler.sv
// Single-transmitter scheduler for the RVVI trace path: arbitrates replay vs fresh
// packets into one frame transmitter, inserts an inter-frame gap and tracks ack timeouts.
module rvvi_tx_scheduler #(
  parameter int WIDTH      = 792,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 50000,
  parameter int TWIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             NewValid,
  input  logic [WIDTH-1:0] NewData,
  output logic             NewReady,
  input  logic             ReplayValid,
  input  logic [WIDTH-1:0] ReplayData,
  output logic             ReplayStall,
  input  logic             ALFull,
  input  logic             ALEmpty,
  input  logic             ALWait,
  input  logic             AckValid,
  output logic             TxValid,
  output logic [WIDTH-1:0] TxData,
  input  logic             TxReady,
  output logic             TimeoutPulse,
  output logic [31:0]      NewCount,
  output logic [31:0]      ReplayCount
);

  typedef enum logic [1:0] {S_IDLE, S_NEW, S_REPLAY, S_GAP} state_e;

  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GLOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GW-1:0]     GAP_LOAD = GW'(GLOAD);
  localparam logic [TWIDTH-1:0] T_TERM   = TWIDTH'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              tx_valid_q, tx_valid_d;
  logic [WIDTH-1:0]  tx_data_q, tx_data_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [TWIDTH-1:0] tcnt_q, tcnt_d;
  logic              tpulse_q, tpulse_d;
  logic [31:0]       new_cnt_q, new_cnt_d;
  logic [31:0]       rep_cnt_q, rep_cnt_d;

  // Fresh traffic is held off while a replay is pending or the active list cannot take it.
  assign NewReady     = (state_q == S_IDLE) & ~ReplayValid & ~ALFull & ~ALWait;
  assign ReplayStall  = (state_q != S_IDLE);
  assign TxValid      = tx_valid_q;
  assign TxData       = tx_data_q;
  assign TimeoutPulse = tpulse_q;
  assign NewCount     = new_cnt_q;
  assign ReplayCount  = rep_cnt_q;

  always_comb begin
    state_d    = state_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    gap_d      = gap_q;
    new_cnt_d  = new_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ReplayValid) begin
          tx_data_d  = ReplayData;
          tx_valid_d = 1'b1;
          state_d    = S_REPLAY;
        end else if (NewValid && NewReady) begin
          tx_data_d  = NewData;
          tx_valid_d = 1'b1;
          state_d    = S_NEW;
        end
      end
      S_NEW, S_REPLAY: begin
        if (tx_valid_q && TxReady) begin
          if (state_q == S_NEW) new_cnt_d = new_cnt_q + 32'd1;
          else                  rep_cnt_d = rep_cnt_q + 32'd1;
          tx_valid_d = 1'b0;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // An ack landing on the terminal count clears the counter and suppresses the pulse.
  always_comb begin
    tpulse_d = 1'b0;
    if (AckValid || ALEmpty) begin
      tcnt_d = '0;
    end else if (tcnt_q == T_TERM) begin
      tcnt_d   = '0;
      tpulse_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      gap_q      <= '0;
      tcnt_q     <= '0;
      tpulse_q   <= 1'b0;
      new_cnt_q  <= '0;
      rep_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      gap_q      <= gap_d;
      tcnt_q     <= tcnt_d;
      tpulse_q   <= tpulse_d;
      new_cnt_q  <= new_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

endmodule

// File: tb/tb_rvvi_tx_scheduler.sv
// Scoreboard bench for rvvi_tx_scheduler: frames pushed on acceptance, popped on handshake.
module tb_rvvi_tx_scheduler;
  localparam int WIDTH = 792;
  localparam int GAPC  = 2;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             NewValid, ReplayValid, ALFull, ALEmpty, ALWait, AckValid, TxReady;
  logic [WIDTH-1:0] NewData, ReplayData;
  logic             NewReady, ReplayStall, TxValid, TimeoutPulse;
  logic [WIDTH-1:0] TxData;
  logic [31:0]      NewCount, ReplayCount;

  int compared   = 0;
  int mismatched = 0;
  int exp_new    = 0;
  int exp_rep    = 0;
  logic [WIDTH-1:0] sb_q[$];

  rvvi_tx_scheduler #(.WIDTH(WIDTH), .GAP_CYCLES(GAPC), .TIMEOUT(TMO), .TWIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .NewValid(NewValid), .NewData(NewData), .NewReady(NewReady),
    .ReplayValid(ReplayValid), .ReplayData(ReplayData), .ReplayStall(ReplayStall),
    .ALFull(ALFull), .ALEmpty(ALEmpty), .ALWait(ALWait), .AckValid(AckValid),
    .TxValid(TxValid), .TxData(TxData), .TxReady(TxReady),
    .TimeoutPulse(TimeoutPulse), .NewCount(NewCount), .ReplayCount(ReplayCount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    logic [WIDTH-1:0] e;
    if (!reset && TxValid && TxReady) begin
      compared++;
      if (sb_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected_frame: got %h, expected no frame", TxData[63:0]);
      end else begin
        e = sb_q.pop_front();
        if (TxData !== e) begin
          mismatched++;
          $display("FAIL sb_frame: got %h, expected %h (low 64 bits)", TxData[63:0], e[63:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; NewValid = 0; ReplayValid = 0; ALFull = 0; ALEmpty = 1; ALWait = 0;
    AckValid = 0; TxReady = 1; NewData = '0; ReplayData = '0;
    tick; tick;
    reset = 1'b0;
    @(negedge clk);
    compared++;
    if (TxValid !== 1'b0 || TxData !== '0 || TimeoutPulse !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got v=%b d=%h p=%b, expected 0/0/0", TxValid, TxData[63:0], TimeoutPulse);
    end
    compared++;
    if (NewCount !== 32'd0 || ReplayCount !== 32'd0) begin
      mismatched++;
      $display("FAIL reset_counts: got %0d/%0d, expected 0/0", NewCount, ReplayCount);
    end
    compared++;
    if (NewReady !== 1'b1 || ReplayStall !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got ready=%b stall=%b, expected 1/0", NewReady, ReplayStall);
    end
    tick;
  endtask

  // Continuous fresh traffic: accept, send, two gap cycles, accept again (period 4).
  task automatic test_fresh;
    logic [WIDTH-1:0] d0, d1;
    d0 = {99{8'hA5}};
    d1 = {99{8'h5A}};
    NewValid = 1'b1; NewData = d0; TxReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) NewData = d1;
      if (i == 5) NewValid = 1'b0;
      @(negedge clk);
      if (i == 0) sb_q.push_back(d0);
      if (i == 4) sb_q.push_back(d1);
      compared++;
      if (NewReady !== (i % 4 == 0)) begin
        mismatched++;
        $display("FAIL fresh_ready c%0d: got %b, expected %b", i, NewReady, (i % 4 == 0));
      end
      compared++;
      if (TxValid !== (i % 4 == 1)) begin
        mismatched++;
        $display("FAIL fresh_valid c%0d: got %b, expected %b", i, TxValid, (i % 4 == 1));
      end
      if (i == 2) begin
        compared++;
        if (NewCount !== 32'd1) begin
          mismatched++;
          $display("FAIL fresh_count: got %0d, expected 1", NewCount);
        end
      end
      tick;
    end
    exp_new += 2;
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] d;
    d = {99{8'hC3}};
    NewValid = 1'b1; NewData = d; TxReady = 1'b0;
    @(negedge clk);
    compared++;
    if (NewReady !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_accept: got %b, expected 1", NewReady);
    end
    sb_q.push_back(d);
    tick;
    NewValid = 1'b0; NewData = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      compared++;
      if (TxValid !== 1'b1 || TxData !== d || NewCount !== 32'(exp_new)) begin
        mismatched++;
        $display("FAIL bp_hold c%0d: got v=%b d=%h n=%0d, expected 1/%h/%0d",
                 k, TxValid, TxData[63:0], NewCount, d[63:0], exp_new);
      end
      tick;
    end
    TxReady = 1'b1;
    tick;
    exp_new++;
    @(negedge clk);
    compared++;
    if (NewCount !== 32'(exp_new) || TxValid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_release: got n=%0d v=%b, expected %0d/0", NewCount, TxValid, exp_new);
    end
    tick; tick;
  endtask

  task automatic test_priority;
    logic [WIDTH-1:0] r, n;
    r = {99{8'h3C}};
    n = {99{8'h77}};
    ReplayValid = 1'b1; ReplayData = r; NewValid = 1'b1; NewData = n; TxReady = 1'b1;
    @(negedge clk);
    compared++;
    if (NewReady !== 1'b0 || ReplayStall !== 1'b0) begin
      mismatched++;
      $display("FAIL prio_idle: got ready=%b stall=%b, expected 0/0", NewReady, ReplayStall);
    end
    sb_q.push_back(r);
    tick;
    ReplayValid = 1'b0; NewValid = 1'b0;
    @(negedge clk);
    compared++;
    if (ReplayStall !== 1'b1 || TxValid !== 1'b1) begin
      mismatched++;
      $display("FAIL prio_send: got stall=%b v=%b, expected 1/1", ReplayStall, TxValid);
    end
    tick;
    exp_rep++;
    for (int g = 0; g < GAPC; g++) begin
      @(negedge clk);
      compared++;
      if (ReplayStall !== 1'b1 || TxValid !== 1'b0) begin
        mismatched++;
        $display("FAIL prio_gap g%0d: got stall=%b v=%b, expected 1/0", g, ReplayStall, TxValid);
      end
      tick;
    end
    @(negedge clk);
    compared++;
    if (ReplayStall !== 1'b0 || ReplayCount !== 32'(exp_rep) || NewCount !== 32'(exp_new)) begin
      mismatched++;
      $display("FAIL prio_done: got stall=%b r=%0d n=%0d, expected 0/%0d/%0d",
               ReplayStall, ReplayCount, NewCount, exp_rep, exp_new);
    end
    tick;
  endtask

  task automatic test_blocking;
    NewValid = 1'b1; NewData = {99{8'hEE}};
    for (int m = 0; m < 2; m++) begin
      ALFull = (m == 0);
      ALWait = (m == 1);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        compared++;
        if (NewReady !== 1'b0 || TxValid !== 1'b0) begin
          mismatched++;
          $display("FAIL block m%0d c%0d: got ready=%b v=%b, expected 0/0", m, k, NewReady, TxValid);
        end
        tick;
      end
    end
    ALFull = 1'b0; ALWait = 1'b0; NewValid = 1'b0;
    tick;
  endtask

  task automatic test_reset_midframe;
    NewValid = 1'b1; NewData = {99{8'h99}}; TxReady = 1'b0;
    tick;
    NewValid = 1'b0;
    @(negedge clk);
    compared++;
    if (TxValid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_pre: got v=%b, expected 1", TxValid);
    end
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_new = 0; exp_rep = 0;
    @(negedge clk);
    compared++;
    if (TxValid !== 1'b0 || TxData !== '0 || ReplayStall !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_out: got v=%b d=%h stall=%b, expected 0/0/0", TxValid, TxData[63:0], ReplayStall);
    end
    compared++;
    if (NewCount !== 32'd0 || ReplayCount !== 32'd0) begin
      mismatched++;
      $display("FAIL rst_mid_cnt: got %0d/%0d, expected 0/0", NewCount, ReplayCount);
    end
    TxReady = 1'b1;
    tick;
  endtask

  task automatic test_timeout;
    logic exp_p;
    ALEmpty = 1'b0; AckValid = 1'b0;
    reset = 1'b1; tick; reset = 1'b0;
    for (int e = 1; e <= 205; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp_p = (e == 100) || (e == 200);
      compared++;
      if (TimeoutPulse !== exp_p) begin
        mismatched++;
        $display("FAIL timeout e%0d: got %b, expected %b", e, TimeoutPulse, exp_p);
      end
    end
    reset = 1'b1; tick; reset = 1'b0;
    for (int e = 1; e <= 150; e++) begin
      @(posedge clk);
      #1;
      AckValid = (e == 99);
      @(negedge clk);
      compared++;
      if (TimeoutPulse !== 1'b0) begin
        mismatched++;
        $display("FAIL timeout_ack e%0d: got %b, expected 0", e, TimeoutPulse);
      end
    end
    AckValid = 1'b0; ALEmpty = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_fresh;
    test_backpressure;
    test_priority;
    test_blocking;
    test_reset_midframe;
    test_timeout;
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL sb_leftover: got %0d pending frames, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
